// File: rtl/clk_div_tracker.sv
// clk_div_tracker
//   Recovers the phase of an externally divided clock (clkDivIn) in the clkIn
//   domain. Rising edges of the synchronised input are timed by a period
//   counter; once LOCK_CNT consecutive intervals of exactly DSR cycles are
//   seen, a free-running phase counter is locked to the edges and a clean
//   divided clock is regenerated from it. Any early or missing edge while
//   locked raises a one-cycle perErr and drops back to acquisition.
//
//   Optional feature: define CLKDIV_TRACK_ERRCNT_EN to add the errCnt output,
//   a saturating count of perErr pulses that is cleared only by reset.
//
// Ports
//   clkIn      in   fast clock, all logic on its rising edge
//   rst        in   synchronous active-low reset
//   clkDivIn   in   divided clock, asynchronous to clkIn
//   cntOut     out  recovered phase counter, 0 when not locked
//   clkRecOut  out  regenerated divided clock, high for cnt < DSR/2 while locked
//   locked     out  high while in the locked state
//   perErr     out  one-cycle pulse on a period violation while locked
//   errCnt     out  (CLKDIV_TRACK_ERRCNT_EN only) saturating perErr count
module clk_div_tracker #(
    parameter int DSR         = 4,
    parameter int LOCK_CNT    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clkIn,
    input  logic                   rst,
    input  logic                   clkDivIn,
    output logic [$clog2(DSR)-1:0] cntOut,
    output logic                   clkRecOut,
    output logic                   locked,
    output logic                   perErr
`ifdef CLKDIV_TRACK_ERRCNT_EN
    ,
    output logic [7:0]             errCnt
`endif
);

    localparam int CW = $clog2(DSR);
    localparam int PW = $clog2(2 * DSR + 1);

    localparam logic [PW-1:0] PER_MAX   = PW'(2 * DSR);
    localparam logic [PW-1:0] PER_EXP   = PW'(DSR);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DSR - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(DSR / 2);
    localparam logic [3:0]    GOOD_LOCK = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked
    } stateT;

    stateT            stateQ, stateD;
    logic [SYNC_STAGES-1:0] syncQ;
    logic             prevQ;
    logic             edgeDet;
    logic [PW-1:0]    perQ, perD;
    logic [3:0]       goodQ, goodD;
    logic [CW-1:0]    cntQ, cntD;
    logic             lockedQ;
    logic             perErrQ, perErrD;

    // Synchroniser plus one extra sample of the last stage for edge detection.
    always_ff @(posedge clkIn) begin
        if (!rst) begin
            syncQ <= '0;
            prevQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], clkDivIn};
            prevQ <= syncQ[SYNC_STAGES-1];
        end
    end

    assign edgeDet = syncQ[SYNC_STAGES-1] & ~prevQ;

    always_comb begin
        stateD  = stateQ;
        goodD   = goodQ;
        cntD    = cntQ;
        perErrD = 1'b0;
        // per holds the length of the interval ending in this cycle.
        if (edgeDet) begin
            perD = PW'(1);
        end else if (perQ == PER_MAX) begin
            perD = perQ;
        end else begin
            perD = perQ + PW'(1);
        end

        unique case (stateQ)
            StSearch: begin
                if (edgeDet) begin
                    stateD = StAcquire;
                    goodD  = '0;
                end
            end
            StAcquire: begin
                // An edge wins over a simultaneous per saturation.
                if (edgeDet) begin
                    if (perQ == PER_EXP) begin
                        goodD = goodQ + 4'd1;
                        if (goodQ + 4'd1 == GOOD_LOCK) begin
                            stateD = StLocked;
                            cntD   = '0;
                        end
                    end else begin
                        goodD = '0;
                    end
                end else if (perQ == PER_MAX) begin
                    stateD = StSearch;
                end
            end
            StLocked: begin
                // The edge is due exactly when cnt is at its last value: an
                // edge elsewhere is early, no edge there is late/missing.
                if (edgeDet != (cntQ == CNT_LAST)) begin
                    perErrD = 1'b1;
                    stateD  = StAcquire;
                    goodD   = '0;
                    cntD    = '0;
                end else if (cntQ == CNT_LAST) begin
                    cntD = '0;
                end else begin
                    cntD = cntQ + CW'(1);
                end
            end
            default: begin
                stateD = StSearch;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rst) begin
            stateQ  <= StSearch;
            perQ    <= '0;
            goodQ   <= '0;
            cntQ    <= '0;
            lockedQ <= 1'b0;
            perErrQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            perQ    <= perD;
            goodQ   <= goodD;
            cntQ    <= cntD;
            lockedQ <= (stateD == StLocked);
            perErrQ <= perErrD;
        end
    end

    assign locked    = lockedQ;
    assign perErr    = perErrQ;
    assign cntOut    = lockedQ ? cntQ : '0;
    assign clkRecOut = lockedQ && (cntQ < CNT_HALF);

`ifdef CLKDIV_TRACK_ERRCNT_EN
    logic [7:0] errCntQ;

    always_ff @(posedge clkIn) begin
        if (!rst) begin
            errCntQ <= '0;
        end else if (perErrD && (errCntQ != 8'hFF)) begin
            errCntQ <= errCntQ + 8'd1;
        end
    end

    assign errCnt = errCntQ;
`endif

endmodule

// File: tb/tb_clk_div_tracker.sv
// Bench for clk_div_tracker: a DSR=4/LOCK_CNT=3 instance and a DSR=2/LOCK_CNT=1
// instance share clkIn. Expected outputs come from an interval-based model:
// the period is the distance to the last edge, the phase is the distance to
// the last lock reference, both modulo/saturated with plain arithmetic.
module tb_clk_div_tracker;

    logic       clkIn = 1'b0;
    logic       rst = 1'b0;
    logic       clkDivIn4 = 1'b0;
    logic       clkDivIn2 = 1'b0;
    logic [1:0] cnt4;
    logic [0:0] cnt2;
    logic       clkRec4, clkRec2, locked4, locked2, perErr4, perErr2;
`ifdef CLKDIV_TRACK_ERRCNT_EN
    logic [7:0] errCnt4, errCnt2;
`endif

    always #5 clkIn = ~clkIn;

    clk_div_tracker #(.DSR(4), .LOCK_CNT(3), .SYNC_STAGES(2)) dut4 (
        .clkIn(clkIn), .rst(rst), .clkDivIn(clkDivIn4), .cntOut(cnt4),
        .clkRecOut(clkRec4), .locked(locked4), .perErr(perErr4)
`ifdef CLKDIV_TRACK_ERRCNT_EN
        , .errCnt(errCnt4)
`endif
    );

    clk_div_tracker #(.DSR(2), .LOCK_CNT(1), .SYNC_STAGES(2)) dut2 (
        .clkIn(clkIn), .rst(rst), .clkDivIn(clkDivIn2), .cntOut(cnt2),
        .clkRecOut(clkRec2), .locked(locked2), .perErr(perErr2)
`ifdef CLKDIV_TRACK_ERRCNT_EN
        , .errCnt(errCnt2)
`endif
    );

    // {locked, perErr, clkRecOut, 3-bit cnt}
    logic [5:0] obs4, obs2, exp4, exp2;
    assign obs4 = {locked4, perErr4, clkRec4, 1'b0, cnt4};
    assign obs2 = {locked2, perErr2, clkRec2, 2'b00, cnt2};

    // mode: 0 search, 1 acquire, 2 locked
    typedef struct {
        int         mode;
        int         good;
        int         lastE;
        int         lockRef;
        int         n;
        logic [7:0] h;
        logic       err;
        int         errCnt;
    } mdl_t;

    mdl_t m4, m2;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   errSeen;
    bit   d2Rand = 1'b0;
    logic q4[$];

    // Advance the model by one clkIn cycle. h[0] is the newest driven level.
    function automatic mdl_t mdlStep(input mdl_t m, input int d, input int lc, input int s,
                                     input logic din, input logic rv);
        mdl_t r;
        logic e;
        int   per, ph;
        r     = m;
        r.n   = m.n + 1;
        r.err = 1'b0;
        if (!rv) begin
            r.mode = 0; r.good = 0; r.lastE = r.n; r.lockRef = 0;
            r.h = '0; r.errCnt = 0;
            return r;
        end
        e   = m.h[s-1] & ~m.h[s];
        per = m.n - m.lastE;
        if (per > 2 * d) per = 2 * d;
        ph  = (m.n - m.lockRef - 1) % d;
        case (m.mode)
            0: if (e) begin r.mode = 1; r.good = 0; end
            1: begin
                if (e) begin
                    if (per == d) begin
                        r.good = m.good + 1;
                        if (r.good >= lc) begin r.mode = 2; r.lockRef = m.n; end
                    end else begin
                        r.good = 0;
                    end
                end else if (per == 2 * d) begin
                    r.mode = 0;
                end
            end
            default: begin
                if (e != (ph == d - 1)) begin r.err = 1'b1; r.mode = 1; r.good = 0; end
                else if (e) r.lockRef = m.n;
            end
        endcase
        if (e) r.lastE = m.n;
        if (r.err && r.errCnt < 255) r.errCnt = r.errCnt + 1;
        r.h = {m.h[6:0], din};
        return r;
    endfunction

    function automatic logic [5:0] expOut(input mdl_t m, input int d);
        int   c;
        logic lk;
        lk = (m.mode == 2);
        c  = lk ? (m.n - m.lockRef - 1) % d : 0;
        return {lk, m.err, lk && (c < d / 2), 3'(c)};
    endfunction

    // Drive one cycle (called just after a falling edge), then sample at the next.
    task automatic tick(input logic d4, input logic rv);
        logic d2;
        d2 = d2Rand ? 1'($urandom_range(1, 0)) : ~clkDivIn2;
        clkDivIn4 = d4;
        clkDivIn2 = d2;
        rst = rv;
        m4 = mdlStep(m4, 4, 3, 2, d4, rv);
        m2 = mdlStep(m2, 2, 1, 2, d2, rv);
        @(negedge clkIn);
        exp4 = expOut(m4, 4);
        exp2 = expOut(m2, 2);
        cyc++;
    endtask

    task automatic pushPer(input int p, input int hi);
        for (int i = 0; i < p; i++) q4.push_back(i < hi);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if (obs4 !== 6'b0) begin
                bad++; $display("FAIL reset4 cyc=%0d got=%b exp=%b", cyc, obs4, 6'b0);
            end
            total++;
            if (obs2 !== 6'b0) begin
                bad++; $display("FAIL reset2 cyc=%0d got=%b exp=%b", cyc, obs2, 6'b0);
            end
        end
    endtask

    task automatic test_lock;
        for (int i = 0; i < int'($urandom_range(5, 0)); i++) q4.push_back(1'b0);
        for (int i = 0; i < 10; i++) pushPer(4, 2);
        errSeen = 0;
        while (q4.size() > 0) begin
            tick(q4.pop_front(), 1'b1);
            total++;
            if (obs4 !== exp4) begin
                bad++; $display("FAIL lock4 cyc=%0d got=%b exp=%b", cyc, obs4, exp4);
            end
            total++;
            if (obs2 !== exp2) begin
                bad++; $display("FAIL lock2 cyc=%0d got=%b exp=%b", cyc, obs2, exp2);
            end
            if (perErr4 === 1'b1 || perErr2 === 1'b1) errSeen++;
        end
        total++;
        if (locked4 !== 1'b1 || locked2 !== 1'b1) begin
            bad++; $display("FAIL lock_final got=%b%b exp=11", locked4, locked2);
        end
        total++;
        if (errSeen !== 0) begin
            bad++; $display("FAIL lock_noerr got=%0d exp=0", errSeen);
        end
    endtask

    task automatic test_late;
        pushPer(5, 2);
        for (int i = 0; i < 5; i++) pushPer(4, 2);
        errSeen = 0;
        while (q4.size() > 0) begin
            tick(q4.pop_front(), 1'b1);
            total++;
            if (obs4 !== exp4) begin
                bad++; $display("FAIL late4 cyc=%0d got=%b exp=%b", cyc, obs4, exp4);
            end
            total++;
            if (obs2 !== exp2) begin
                bad++; $display("FAIL late2 cyc=%0d got=%b exp=%b", cyc, obs2, exp2);
            end
            if (perErr4 === 1'b1) errSeen++;
        end
        total++;
        if (errSeen !== 1 || locked4 !== 1'b1) begin
            bad++; $display("FAIL late_err got=%0d/%b exp=1/1", errSeen, locked4);
        end
    endtask

    task automatic test_missing;
        for (int i = 0; i < 12; i++) q4.push_back(1'b0);
        for (int i = 0; i < 6; i++) pushPer(4, 1);
        errSeen = 0;
        while (q4.size() > 0) begin
            tick(q4.pop_front(), 1'b1);
            total++;
            if (obs4 !== exp4) begin
                bad++; $display("FAIL miss4 cyc=%0d got=%b exp=%b", cyc, obs4, exp4);
            end
            total++;
            if (obs2 !== exp2) begin
                bad++; $display("FAIL miss2 cyc=%0d got=%b exp=%b", cyc, obs2, exp2);
            end
            if (perErr4 === 1'b1) errSeen++;
        end
        total++;
        if (errSeen !== 1 || locked4 !== 1'b1) begin
            bad++; $display("FAIL miss_err got=%0d/%b exp=1/1", errSeen, locked4);
        end
    endtask

    task automatic test_reset_mid;
        total++;
        if (locked4 !== 1'b1) begin
            bad++; $display("FAIL rmid_pre got=%b exp=1", locked4);
        end
        tick(1'b0, 1'b0);
        total++;
        if (obs4 !== 6'b0 || obs2 !== 6'b0) begin
            bad++; $display("FAIL rmid_zero got=%b/%b exp=0", obs4, obs2);
        end
        for (int i = 0; i < 6; i++) pushPer(4, 3);
        while (q4.size() > 0) begin
            tick(q4.pop_front(), 1'b1);
            total++;
            if (obs4 !== exp4) begin
                bad++; $display("FAIL rmid4 cyc=%0d got=%b exp=%b", cyc, obs4, exp4);
            end
            total++;
            if (obs2 !== exp2) begin
                bad++; $display("FAIL rmid2 cyc=%0d got=%b exp=%b", cyc, obs2, exp2);
            end
        end
        total++;
        if (locked4 !== 1'b1) begin
            bad++; $display("FAIL rmid_relock got=%b exp=1", locked4);
        end
    endtask

    task automatic test_random;
        int p;
        d2Rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            p = ($urandom_range(9, 0) < 6) ? 4 : int'($urandom_range(9, 2));
            pushPer(p, int'($urandom_range(p - 1, 1)));
        end
        while (q4.size() > 0) begin
            tick(q4.pop_front(), 1'b1);
            total++;
            if (obs4 !== exp4) begin
                bad++; $display("FAIL rand4 cyc=%0d got=%b exp=%b", cyc, obs4, exp4);
            end
            total++;
            if (obs2 !== exp2) begin
                bad++; $display("FAIL rand2 cyc=%0d got=%b exp=%b", cyc, obs2, exp2);
            end
        end
        d2Rand = 1'b0;
    endtask

`ifdef CLKDIV_TRACK_ERRCNT_EN
    task automatic test_errcnt;
        for (int i = 0; i < 300; i++) begin
            pushPer(3, 1);
            for (int j = 0; j < 3; j++) pushPer(4, 2);
        end
        while (q4.size() > 0) begin
            tick(q4.pop_front(), 1'b1);
            total++;
            if (obs4 !== exp4 || errCnt4 !== 8'(m4.errCnt)) begin
                bad++; $display("FAIL errc4 cyc=%0d got=%b/%0d exp=%b/%0d",
                                cyc, obs4, errCnt4, exp4, m4.errCnt);
            end
            total++;
            if (obs2 !== exp2 || errCnt2 !== 8'(m2.errCnt)) begin
                bad++; $display("FAIL errc2 cyc=%0d got=%b/%0d exp=%b/%0d",
                                cyc, obs2, errCnt2, exp2, m2.errCnt);
            end
        end
        total++;
        if (errCnt4 !== 8'd255) begin
            bad++; $display("FAIL errc_sat got=%0d exp=255", errCnt4);
        end
    endtask
`endif

    initial begin
        m4 = '{default: 0};
        m2 = '{default: 0};
        @(negedge clkIn);
        test_reset;
        test_lock;
        test_late;
        test_missing;
        test_reset_mid;
        test_random;
`ifdef CLKDIV_TRACK_ERRCNT_EN
        test_errcnt;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
